mem_port_arbiter: RTL

//  Shares one single-ported unified instruction/data memory between the IF stage (read-only)
//  and the MEM stage (read/write) of the 5-stage MIPS pipeline. Serialises accesses, drives a

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports and memory handshake bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // master: the arbiter itself; slave: pipeline stages plus memory model
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one shared memory port with stall and watchdog (ARB_RR_EN: round-robin ties)
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output logic                stall,
    output logic                tmo_err
);

    localparam int WW = $clog2(TMO_CYC + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TMO_CYC - 1);
    localparam logic [DW-1:0] TMO_DATA  = DW'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    logic [WW-1:0] wdog;
    logic          grant_d;
    logic          rsp_done;
    logic [DW-1:0] rsp_data;

`ifdef ARB_RR_EN
    logic last_d;   // winner of the most recent tie: 1 = data, 0 = fetch

    assign grant_d = bus.d_req & (~bus.if_req | ~last_d);
`else
    assign grant_d = bus.d_req;
`endif

    // A timeout completes the access exactly like a response, just with poison data.
    assign rsp_done = bus.mem_ready | (wdog == WDOG_LAST);
    assign rsp_data = bus.mem_ready ? bus.mem_rdata : TMO_DATA;

    assign stall = (bus.if_req & ~bus.if_valid) | (bus.d_req & ~bus.d_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wdog          <= '0;
            tmo_err       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.if_valid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_valid   <= 1'b0;
`ifdef ARB_RR_EN
            last_d        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (grant_d) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        state         <= BUSY_D;
                    end else if (bus.if_req) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                        state         <= BUSY_IF;
                    end
`ifdef ARB_RR_EN
                    // Only contested grants move the pointer; lone requests do not.
                    if (bus.d_req && bus.if_req) begin
                        last_d <= grant_d;
                    end
`endif
                end

                BUSY_IF, BUSY_D: begin
                    if (rsp_done) begin
                        if (state == BUSY_D) begin
                            bus.d_rdata <= rsp_data;
                            bus.d_valid <= 1'b1;
                        end else begin
                            bus.if_rdata <= rsp_data;
                            bus.if_valid <= 1'b1;
                        end
                        if (!bus.mem_ready) begin
                            tmo_err <= 1'b1;
                        end
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                DONE: begin
                    bus.if_valid <= 1'b0;
                    bus.d_valid  <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
